carfield_l2_dual_port_scheduler: RTL and testbench

- Shares the two L2 SPM ports between NumReq memory-style requesters.
- Port 0 covers [L2Port0Base, L2Port0Base+L2PortSize). Port 1 is contiguous above it and the same size.
- Each port has its own round-robin arbiter. Responses are routed back by an in-order ID FIFO per port, and out-of-range accesses get an error response.
- Sits between the host/DMA/cluster narrow masters and the dual-port L2 macro wrapper.

---
 rtl/carfield_l2_dual_port_scheduler.sv | 134 +++++++++++++
 tb/tb_carfield_l2_dual_port_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carfield_l2_dual_port_scheduler.sv
// carfield_l2_dual_port_scheduler: shares the two L2 SPM ports between NumReq requesters
module carfield_l2_dual_port_scheduler #(
    parameter int unsigned          NumReq         = 4,
    parameter int unsigned          AddrWidth      = 48,
    parameter int unsigned          DataWidth      = 64,
    parameter logic [AddrWidth-1:0] L2Port0Base    = 'h78000000,
    parameter logic [AddrWidth-1:0] L2PortSize     = 'h00020000,
    parameter int unsigned          MaxOutstanding = 4,
    localparam int unsigned         BeWidth        = DataWidth / 8,
    localparam int unsigned         OffWidth       = $clog2(L2PortSize)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumReq-1:0]                   req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
    input  logic [NumReq-1:0]                   we_i,
    input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
    output logic [NumReq-1:0]                   gnt_o,
    output logic [NumReq-1:0]                   rvalid_o,
    output logic [NumReq-1:0][DataWidth-1:0]    rdata_o,
    output logic [NumReq-1:0]                   err_o,
    output logic [1:0]                          l2_req_o,
    output logic [1:0][OffWidth-1:0]            l2_addr_o,
    output logic [1:0]                          l2_we_o,
    output logic [1:0][BeWidth-1:0]             l2_be_o,
    output logic [1:0][DataWidth-1:0]           l2_wdata_o,
    input  logic [1:0]                          l2_gnt_i,
    input  logic [1:0]                          l2_rvalid_i,
    input  logic [1:0][DataWidth-1:0]           l2_rdata_i
);
    localparam int unsigned IdxWidth = $clog2(NumReq);
    localparam int unsigned PtrWidth = $clog2(MaxOutstanding);
    localparam int unsigned CntWidth = $clog2(2 * MaxOutstanding + 2);

    logic [NumReq-1:0][AddrWidth-1:0] off;
    logic [NumReq-1:0][1:0]           dst;
    logic [NumReq-1:0]                is_err, err_gnt, err_q, last_port;
    logic [1:0][NumReq-1:0]           elig;
    logic [1:0][IdxWidth-1:0]         win, rr_ptr;
    logic [1:0]                       has, hs, pop, full, empty;
    logic [1:0][PtrWidth:0]           wr_ptr, rd_ptr;
    logic [1:0][IdxWidth:0]           head;
    logic [IdxWidth:0]                id_fifo [2][MaxOutstanding];
    logic [NumReq-1:0][CntWidth-1:0]  outstanding;
    int                               j;

    // Address decode, error grants and per-port eligibility; a pop frees a slot in the same cycle
    always_comb begin
        for (int i = 0; i < int'(NumReq); i++) begin
            off[i] = addr_i[i] - L2Port0Base;
            dst[i][0] = off[i] < L2PortSize;
            dst[i][1] = !dst[i][0] && (off[i] < (L2PortSize << 1));
            is_err[i] = !dst[i][0] && !dst[i][1];
            err_gnt[i] = !rst_i && req_i[i] && is_err[i] && (outstanding[i] == '0);
        end
        for (int p = 0; p < 2; p++) begin
            full[p] = (wr_ptr[p] - rd_ptr[p]) == (PtrWidth + 1)'(MaxOutstanding);
            empty[p] = wr_ptr[p] == rd_ptr[p];
            pop[p] = l2_rvalid_i[p] && !empty[p];
            head[p] = id_fifo[p][rd_ptr[p][PtrWidth-1:0]];
            for (int i = 0; i < int'(NumReq); i++)
                elig[p][i] = !rst_i && req_i[i] && dst[i][p] && !(full[p] && !pop[p]) &&
                             (outstanding[i] == '0 || last_port[i] == 1'(p));
        end
    end

    // Round-robin search from each port's pointer; the winner drives that port's request fields
    always_comb begin
        win = '0;
        has = '0;
        j = 0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < int'(NumReq); k++) begin
                j = (int'(rr_ptr[p]) + k) % int'(NumReq);
                if (!has[p] && elig[p][j]) begin
                    has[p] = 1'b1;
                    win[p] = IdxWidth'(j);
                end
            end
            hs[p] = has[p] && l2_gnt_i[p];
            l2_req_o[p] = has[p];
            l2_addr_o[p] = has[p] ? off[win[p]][OffWidth-1:0] : '0;
            l2_we_o[p] = has[p] && we_i[win[p]];
            l2_be_o[p] = has[p] ? be_i[win[p]] : '0;
            l2_wdata_o[p] = has[p] ? wdata_i[win[p]] : '0;
        end
    end

    // Requester-side grants and responses; write and error responses return zero data
    always_comb begin
        gnt_o = err_gnt;
        rvalid_o = err_q;
        err_o = err_q;
        rdata_o = '0;
        for (int p = 0; p < 2; p++) begin
            if (hs[p]) gnt_o[win[p]] = 1'b1;
            if (pop[p]) begin
                rvalid_o[head[p][IdxWidth-1:0]] = 1'b1;
                rdata_o[head[p][IdxWidth-1:0]] = head[p][IdxWidth] ? '0 : l2_rdata_i[p];
            end
        end
    end

    // Pointers, port locks, outstanding counters and the one-cycle error pipeline
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_port   <= '0;
            outstanding <= '0;
            err_q       <= '0;
        end else begin
            err_q <= err_gnt;
            for (int p = 0; p < 2; p++) begin
                if (hs[p]) begin
                    rr_ptr[p] <= IdxWidth'((int'(win[p]) + 1) % int'(NumReq));
                    wr_ptr[p] <= wr_ptr[p] + 1'b1;
                    last_port[win[p]] <= 1'(p);
                end
                if (pop[p]) rd_ptr[p] <= rd_ptr[p] + 1'b1;
            end
            for (int i = 0; i < int'(NumReq); i++)
                outstanding[i] <= outstanding[i] + CntWidth'(gnt_o[i]) - CntWidth'(rvalid_o[i]);
        end
    end

    // ID FIFO storage: requester index plus a write flag so write responses return zero data
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < 2; p++)
            if (hs[p]) id_fifo[p][wr_ptr[p][PtrWidth-1:0]] <= {l2_we_o[p], win[p]};
    end
endmodule

// File: tb/tb_carfield_l2_dual_port_scheduler.sv
// tb_carfield_l2_dual_port_scheduler: vector table, directed corner cases and a queue-based reference model
module tb_carfield_l2_dual_port_scheduler;
    localparam int N = 4, AW = 48, DW = 64, BW = 8, MO = 4;
    localparam logic [47:0] BASE = 'h78000000, SIZE = 'h00020000;

    logic clk = 1'b0, rst_i = 1'b1;
    logic [N-1:0] req_i, we_i, gnt_o, rvalid_o, err_o;
    logic [N-1:0][AW-1:0] addr_i;
    logic [N-1:0][BW-1:0] be_i;
    logic [N-1:0][DW-1:0] wdata_i, rdata_o;
    logic [1:0] l2_req_o, l2_we_o, l2_gnt_i, l2_rvalid_i;
    logic [1:0][16:0] l2_addr_o;
    logic [1:0][BW-1:0] l2_be_o;
    logic [1:0][DW-1:0] l2_wdata_o, l2_rdata_i;

    int n_checks = 0, n_err = 0;

    int mq[2][$];
    int m_out[N], m_last[N], m_rr[2];
    bit m_errp[N];

    typedef struct {
        logic [47:0] addr;
        logic [1:0]  l2req;
        logic [16:0] l2addr;
        logic        gnt;
        logic        err;
    } vec_t;
    vec_t tbl[9];
    logic [1:0][16:0] ea;

    carfield_l2_dual_port_scheduler #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .L2Port0Base(BASE),
        .L2PortSize(SIZE), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o),
        .l2_we_o(l2_we_o), .l2_be_o(l2_be_o), .l2_wdata_o(l2_wdata_o),
        .l2_gnt_i(l2_gnt_i), .l2_rvalid_i(l2_rvalid_i), .l2_rdata_i(l2_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        req_i = '0; we_i = '0; addr_i = '0; be_i = '0; wdata_i = '0;
        l2_gnt_i = '0; l2_rvalid_i = '0; l2_rdata_i = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int port_of(input logic [47:0] a);
        logic [47:0] o;
        o = a - BASE;
        if (o < SIZE) return 0;
        if (o < SIZE + SIZE) return 1;
        return 2;
    endfunction

    function automatic logic [16:0] port_off(input logic [47:0] a);
        logic [47:0] o;
        o = a - BASE;
        if (o >= SIZE) o = o - SIZE;
        return o[16:0];
    endfunction

    function automatic logic [47:0] rand_addr();
        int r;
        logic [47:0] o;
        r = $urandom_range(0, 19);
        o = 48'($urandom_range(0, 'h3FFF)) << 3;
        if (r < 9) return BASE + o;
        if (r < 18) return BASE + SIZE + o;
        if (r == 18) return BASE + SIZE + SIZE + o;
        return BASE - 48'd8 - o;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            mq[p].delete();
            m_rr[p] = 0;
        end
        for (int i = 0; i < N; i++) begin
            m_out[i] = 0; m_last[i] = 0; m_errp[i] = 0;
        end
    endtask

    task automatic model_step();
        int dst[N], win[2], j, h;
        bit pop[2], egnt[N];
        logic [N-1:0] e_gnt, e_rv, e_err;
        logic [N-1:0][DW-1:0] e_rd;
        logic [1:0] e_req, e_we;
        logic [1:0][16:0] e_addr;
        logic [1:0][BW-1:0] e_be;
        logic [1:0][DW-1:0] e_wd;
        e_gnt = '0; e_rv = '0; e_err = '0; e_rd = '0;
        e_req = '0; e_we = '0; e_addr = '0; e_be = '0; e_wd = '0;
        for (int i = 0; i < N; i++) dst[i] = port_of(addr_i[i]);
        for (int p = 0; p < 2; p++) begin
            pop[p] = l2_rvalid_i[p] && mq[p].size() > 0;
            win[p] = -1;
            if (mq[p].size() - int'(pop[p]) < MO)
                for (int k = 0; k < N; k++) begin
                    j = (m_rr[p] + k) % N;
                    if (win[p] < 0 && req_i[j] && dst[j] == p && (m_out[j] == 0 || m_last[j] == p)) win[p] = j;
                end
            if (win[p] >= 0) begin
                e_req[p] = 1'b1;
                e_addr[p] = port_off(addr_i[win[p]]);
                e_we[p] = we_i[win[p]];
                e_be[p] = be_i[win[p]];
                e_wd[p] = wdata_i[win[p]];
                if (l2_gnt_i[p]) e_gnt[win[p]] = 1'b1;
            end
            if (pop[p]) begin
                h = mq[p][0];
                e_rv[h % 8] = 1'b1;
                e_rd[h % 8] = (h >= 8) ? '0 : l2_rdata_i[p];
            end
        end
        for (int i = 0; i < N; i++) begin
            egnt[i] = req_i[i] && dst[i] == 2 && m_out[i] == 0;
            if (egnt[i]) e_gnt[i] = 1'b1;
            if (m_errp[i]) begin
                e_rv[i] = 1'b1;
                e_err[i] = 1'b1;
            end
        end
        check("rnd_gnt", 256'(gnt_o), 256'(e_gnt));
        check("rnd_rvalid", 256'(rvalid_o), 256'(e_rv));
        check("rnd_err", 256'(err_o), 256'(e_err));
        check("rnd_rdata", 256'(rdata_o), 256'(e_rd));
        check("rnd_l2_ctl", 256'({l2_be_o, l2_we_o, l2_req_o}), 256'({e_be, e_we, e_req}));
        check("rnd_l2_addr", 256'(l2_addr_o), 256'(e_addr));
        check("rnd_l2_wdata", 256'(l2_wdata_o), 256'(e_wd));
        for (int p = 0; p < 2; p++)
            if (pop[p]) begin
                h = mq[p].pop_front();
                m_out[h % 8]--;
            end
        for (int p = 0; p < 2; p++)
            if (win[p] >= 0 && l2_gnt_i[p]) begin
                mq[p].push_back(win[p] + 8 * int'(we_i[win[p]]));
                m_out[win[p]]++;
                m_last[win[p]] = p;
                m_rr[p] = (win[p] + 1) % N;
            end
        for (int i = 0; i < N; i++) begin
            if (m_errp[i]) m_out[i]--;
            m_errp[i] = egnt[i];
            if (egnt[i]) m_out[i]++;
        end
    endtask

    initial begin
        tbl[0] = '{48'h78000010,   2'b01, 17'h00010, 1'b0, 1'b0};
        tbl[1] = '{48'h78020010,   2'b10, 17'h00010, 1'b0, 1'b0};
        tbl[2] = '{48'h7801FFF8,   2'b01, 17'h1FFF8, 1'b0, 1'b0};
        tbl[3] = '{48'h78020000,   2'b10, 17'h00000, 1'b0, 1'b0};
        tbl[4] = '{48'h7803FFF8,   2'b10, 17'h1FFF8, 1'b0, 1'b0};
        tbl[5] = '{48'h78040000,   2'b00, 17'h00000, 1'b1, 1'b1};
        tbl[6] = '{48'h70000000,   2'b00, 17'h00000, 1'b1, 1'b1};
        tbl[7] = '{48'h77FFFFF8,   2'b00, 17'h00000, 1'b1, 1'b1};
        tbl[8] = '{48'hFFFF78000010, 2'b00, 17'h00000, 1'b1, 1'b1};

        clear_in();
        req_i = '1;
        for (int i = 0; i < N; i++) addr_i[i] = BASE;
        l2_gnt_i = 2'b11;
        l2_rvalid_i = 2'b11;
        #2;
        check("rst_gnt", 256'(gnt_o), 256'(0));
        check("rst_l2_req", 256'(l2_req_o), 256'(0));
        check("rst_rvalid", 256'(rvalid_o), 256'(0));
        check("rst_err", 256'(err_o), 256'(0));
        check("rst_rdata", 256'(rdata_o), 256'(0));
        clear_in();
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        for (int t = 0; t < 9; t++) begin
            cyc();
            req_i = 4'b0001;
            addr_i[0] = tbl[t].addr;
            #4;
            ea = '0;
            if (tbl[t].l2req[0]) ea[0] = tbl[t].l2addr;
            if (tbl[t].l2req[1]) ea[1] = tbl[t].l2addr;
            check($sformatf("tbl%0d_l2_req", t), 256'(l2_req_o), 256'(tbl[t].l2req));
            check($sformatf("tbl%0d_l2_addr", t), 256'(l2_addr_o), 256'(ea));
            check($sformatf("tbl%0d_gnt", t), 256'(gnt_o[0]), 256'(tbl[t].gnt));
            cyc();
            req_i = '0;
            #4;
            check($sformatf("tbl%0d_rvalid", t), 256'(rvalid_o[0]), 256'(tbl[t].err));
            check($sformatf("tbl%0d_err", t), 256'(err_o[0]), 256'(tbl[t].err));
            check($sformatf("tbl%0d_rdata", t), 256'(rdata_o[0]), 256'(0));
        end

        cyc();
        req_i = 4'b0001; addr_i[0] = 48'h78000010; l2_gnt_i = 2'b11;
        #4;
        check("lock_gnt0", 256'(gnt_o), 256'(4'b0001));
        check("lock_l2_addr0", 256'(l2_addr_o), 256'({17'h0, 17'h10}));
        cyc();
        addr_i[0] = 48'h78020010;
        #4;
        check("lock_held_gnt", 256'(gnt_o), 256'(0));
        check("lock_held_req", 256'(l2_req_o), 256'(0));
        cyc();
        l2_rvalid_i = 2'b01; l2_rdata_i[0] = 64'hDEAD_BEEF_0123_4567;
        #4;
        check("lock_rvalid0", 256'(rvalid_o), 256'(4'b0001));
        check("lock_rdata0", 256'(rdata_o[0]), 256'(64'hDEAD_BEEF_0123_4567));
        check("lock_still_held", 256'(gnt_o), 256'(0));
        cyc();
        l2_rvalid_i = '0;
        #4;
        check("lock_gnt1", 256'(gnt_o), 256'(4'b0001));
        check("lock_l2_req1", 256'(l2_req_o), 256'(2'b10));
        check("lock_l2_addr1", 256'(l2_addr_o), 256'({17'h10, 17'h0}));
        cyc();
        req_i = '0; l2_rvalid_i = 2'b10; l2_rdata_i[1] = 64'h0000_1111_2222_3333;
        #4;
        check("lock_rvalid1", 256'(rvalid_o), 256'(4'b0001));
        check("lock_rdata1", 256'(rdata_o[0]), 256'(64'h0000_1111_2222_3333));
        cyc();
        clear_in();

        cyc();
        req_i = 4'b0001; addr_i[0] = 48'h78000100; we_i = 4'b0001; l2_gnt_i = 2'b01;
        #4;
        check("full_gnt_1", 256'(gnt_o), 256'(4'b0001));
        for (int k = 2; k <= 4; k++) begin
            cyc();
            #4;
            check($sformatf("full_gnt_%0d", k), 256'(gnt_o), 256'(4'b0001));
        end
        cyc();
        #4;
        check("full_blocked_gnt", 256'(gnt_o), 256'(0));
        check("full_blocked_req", 256'(l2_req_o), 256'(0));
        cyc();
        l2_rvalid_i = 2'b01; l2_rdata_i[0] = 64'h1234;
        #4;
        check("full_pushpop_gnt", 256'(gnt_o), 256'(4'b0001));
        check("full_pushpop_rvalid", 256'(rvalid_o), 256'(4'b0001));
        check("full_write_rdata", 256'(rdata_o[0]), 256'(0));
        cyc();
        l2_rvalid_i = '0;
        #4;
        check("full_still_full", 256'(gnt_o), 256'(0));
        req_i = '0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            l2_rvalid_i = 2'b01;
            #4;
            check($sformatf("drain_rvalid_%0d", k), 256'(rvalid_o), 256'(4'b0001));
        end
        cyc();
        #4;
        check("empty_rvalid_ignored", 256'(rvalid_o), 256'(0));
        cyc();
        clear_in();

        cyc();
        req_i = 4'b0111; l2_gnt_i = 2'b01;
        for (int i = 0; i < 3; i++) addr_i[i] = 48'h78000200;
        #4;
        check("rr_gnt_a", 256'(gnt_o), 256'(4'b0010));
        cyc();
        #4;
        check("rr_gnt_b", 256'(gnt_o), 256'(4'b0100));
        cyc();
        #4;
        check("rr_gnt_c", 256'(gnt_o), 256'(4'b0001));
        cyc();
        rst_i = 1'b1;
        #1;
        check("midrst_gnt", 256'(gnt_o), 256'(0));
        check("midrst_l2_req", 256'(l2_req_o), 256'(0));
        l2_rvalid_i = 2'b01; l2_rdata_i[0] = 64'h5555;
        #1;
        check("midrst_rvalid", 256'(rvalid_o), 256'(0));
        cyc();
        rst_i = 1'b0; req_i = '0;
        #4;
        check("postrst_dropped", 256'(rvalid_o), 256'(0));
        cyc();
        l2_rvalid_i = '0; req_i = 4'b0111;
        #4;
        check("postrst_gnt", 256'(gnt_o), 256'(4'b0001));
        check("postrst_l2_req", 256'(l2_req_o), 256'(2'b01));
        cyc();
        req_i = '0; l2_rvalid_i = 2'b01; l2_rdata_i[0] = 64'hABCD;
        #4;
        check("postrst_rvalid", 256'(rvalid_o), 256'(4'b0001));
        check("postrst_rdata", 256'(rdata_o[0]), 256'(64'hABCD));
        cyc();
        l2_rvalid_i = '0;
        #4;
        check("postrst_idle", 256'(rvalid_o), 256'(0));

        clear_in();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                req_i[i] = $urandom_range(0, 9) < 6;
                we_i[i] = 1'($urandom_range(0, 1));
                be_i[i] = 8'($urandom);
                wdata_i[i] = {$urandom, $urandom};
                addr_i[i] = rand_addr();
            end
            for (int p = 0; p < 2; p++) begin
                l2_gnt_i[p] = $urandom_range(0, 3) != 0;
                l2_rvalid_i[p] = 1'($urandom_range(0, 1));
                l2_rdata_i[p] = {$urandom, $urandom};
            end
            #4;
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
